demux_rr_dispatcher: RTL and testbench

Controller that sequences the 1-to-4 byte demultiplexer. It accepts a valid/ready input stream, picks a destination channel per word (round-robin over free channels, or directed by a per-word destination field), and holds each routed word in a one-deep per-channel output register until that consumer accepts it. It drives the select code and exposes busy/idle status to the sequencing logic above it.

---
 rtl/demux_rr_dispatcher_if.sv | 29 ++
 rtl/demux_rr_dispatcher.sv | 130 +++++++++++++
 tb/tb_demux_rr_dispatcher.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/demux_rr_dispatcher_if.sv
`default_nettype none
// ============================================================================
// Module   : demux_rr_dispatcher_if
// Brief    : Input stream / per-channel output bus of the 1-to-4 dispatcher.
// Revision : 1.0 - initial release
// ============================================================================
interface demux_rr_dispatcher_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0]   in_data;
  logic [1:0]         in_dest;
  logic               in_valid;
  logic               in_ready;
  logic [4*WIDTH-1:0] out_data;
  logic [3:0]         out_valid;
  logic [3:0]         out_ready;
  logic [1:0]         sel;

  modport master (
    output in_data, in_dest, in_valid, out_ready,
    input  in_ready, out_data, out_valid, sel
  );

  modport slave (
    input  in_data, in_dest, in_valid, out_ready,
    output in_ready, out_data, out_valid, sel
  );
endinterface
`default_nettype wire

// File: rtl/demux_rr_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : demux_rr_dispatcher
// Brief    : Routes a valid/ready word stream to four one-deep channel slots,
//            round-robin over free slots or directed by a per-word field.
// Revision : 1.0 - initial release
// ============================================================================
module demux_rr_dispatcher #(
  parameter int WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic                        mode_dir,
  output logic                        idle,
  demux_rr_dispatcher_if.slave        bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DRAIN  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         ptr_q, ptr_d;
  logic               mode_q, mode_d;
  logic [3:0]         vld_q, vld_d;
  logic [4*WIDTH-1:0] data_q, data_d;

  logic [3:0] slot_free;
  logic [1:0] target;
  logic       has_target;
  logic       active;
  logic       ready_w;
  logic       xfer;

  // A slot whose consumer takes its word this cycle can be reloaded at once.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_free
      assign slot_free[gi] = ~vld_q[gi] | bus.out_ready[gi];
    end
  endgenerate

  always_comb begin : target_sel
    logic [1:0] cand;
    cand       = 2'd0;
    target     = 2'd0;
    has_target = 1'b0;
    if (mode_q) begin
      target     = bus.in_dest;
      has_target = slot_free[bus.in_dest];
    end else begin
      // Scan from farthest to nearest so the slot closest to ptr wins.
      for (int k = 3; k >= 0; k--) begin
        cand = ptr_q + 2'(k);
        if (slot_free[cand]) begin
          target     = cand;
          has_target = 1'b1;
        end
      end
    end
  end

  assign active  = (state_q == S_ACTIVE);
  assign ready_w = active & has_target;
  assign xfer    = bus.in_valid & ready_w;

  always_comb begin : next_state
    state_d = state_q;
    ptr_d   = ptr_q;
    mode_d  = mode_q;
    vld_d   = vld_q & ~bus.out_ready;
    data_d  = data_q;

    for (int i = 0; i < 4; i++) begin
      if (xfer && (target == 2'(i))) begin
        vld_d[i]                  = 1'b1;
        data_d[i*WIDTH +: WIDTH]  = bus.in_data;
      end
    end
    if (xfer && !mode_q) begin
      ptr_d = target + 2'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (en) begin
          state_d = S_ACTIVE;
          mode_d  = mode_dir;
        end
      end
      S_ACTIVE: begin
        if (!en) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (vld_q == 4'd0) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= 2'd0;
      mode_q  <= 1'b0;
      vld_q   <= 4'd0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      mode_q  <= mode_d;
      vld_q   <= vld_d;
      data_q  <= data_d;
    end
  end

  assign bus.in_ready  = ready_w;
  assign bus.sel       = ready_w ? target : 2'd0;
  assign bus.out_data  = data_q;
  assign bus.out_valid = vld_q;
  assign idle          = (state_q == S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_demux_rr_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux_rr_dispatcher
// Brief    : Vector table with per-channel delivery scoreboard for the dispatcher.
// Revision : 1.0 - initial release
// ============================================================================
module tb_demux_rr_dispatcher;
  localparam int   WIDTH = 8;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;
  localparam int   NV = 43;

  typedef struct {
    logic       r;
    logic       e;
    logic       m;
    logic       v;
    logic [7:0] data;
    logic [1:0] dest;
    logic [3:0] ordy;
    logic       rdy;
    logic [1:0] sel;
    logic       idle;
    logic [3:0] ov;
    logic [2:0] dchk;
    logic [7:0] dval;
  } vec_t;

  typedef logic [7:0] byte_q_t[$];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic mode_dir = 1'b0;
  logic idle;

  demux_rr_dispatcher_if #(.WIDTH(WIDTH)) bus();

  demux_rr_dispatcher #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .mode_dir (mode_dir),
    .idle     (idle),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int      total = 0;
  int      bad = 0;
  byte_q_t sbq [4];
  vec_t    vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input int idx, input vec_t t);
    logic [7:0] got;
    logic [7:0] want;
    rst_n        = t.r;
    en           = t.e;
    mode_dir     = t.m;
    bus.in_valid = t.v;
    bus.in_data  = t.data;
    bus.in_dest  = t.dest;
    bus.out_ready = t.ordy;
    #4;
    chk($sformatf("in_ready row%0d", idx), 32'(bus.in_ready), 32'(t.rdy));
    chk($sformatf("sel row%0d", idx), 32'(bus.sel), 32'(t.sel));
    chk($sformatf("idle row%0d", idx), 32'(idle), 32'(t.idle));
    chk($sformatf("out_valid row%0d", idx), 32'(bus.out_valid), 32'(t.ov));
    if (t.dchk[2]) begin
      got = 8'(bus.out_data >> (8 * int'(t.dchk[1:0])));
      chk($sformatf("out_data ch%0d row%0d", t.dchk[1:0], idx), 32'(got), 32'(t.dval));
    end
    if (t.r) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.out_valid[i] && t.ordy[i]) begin
          got = bus.out_data[i*8 +: 8];
          if (sbq[i].size() == 0) begin
            total++;
            bad++;
            $display("FAIL deliver ch%0d row%0d: got %0h expected no word", i, idx, got);
          end else begin
            want = sbq[i].pop_front();
            chk($sformatf("deliver ch%0d row%0d", i, idx), 32'(got), 32'(want));
          end
        end
      end
      if (t.v && t.rdy) sbq[t.sel].push_back(t.data);
    end else begin
      for (int i = 0; i < 4; i++) sbq[i].delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // r  e  m  v  data   dest  ordy  rdy sel  idle ov    dchk  dval
    vecs[0]  = '{H, H, L, L, 8'h00, 2'd0, 4'hF, L, 2'd0, H, 4'h0, 3'd0, 8'h00};
    vecs[1]  = '{H, H, L, H, 8'h11, 2'd0, 4'hF, H, 2'd0, L, 4'h0, 3'd0, 8'h00};
    vecs[2]  = '{H, H, L, H, 8'h22, 2'd0, 4'hF, H, 2'd1, L, 4'h1, 3'd0, 8'h00};
    vecs[3]  = '{H, H, L, H, 8'h33, 2'd0, 4'hF, H, 2'd2, L, 4'h2, 3'd0, 8'h00};
    vecs[4]  = '{H, H, L, H, 8'h44, 2'd0, 4'hF, H, 2'd3, L, 4'h4, 3'd0, 8'h00};
    vecs[5]  = '{H, H, L, H, 8'h55, 2'd0, 4'hF, H, 2'd0, L, 4'h8, 3'd0, 8'h00};
    vecs[6]  = '{H, H, L, L, 8'h00, 2'd0, 4'hF, H, 2'd1, L, 4'h1, 3'd0, 8'h00};
    // ch1 stalls while the pointer walks back round to it
    vecs[7]  = '{H, H, L, H, 8'hB1, 2'd0, 4'hD, H, 2'd1, L, 4'h0, 3'd0, 8'h00};
    vecs[8]  = '{H, H, L, H, 8'hB2, 2'd0, 4'hD, H, 2'd2, L, 4'h2, 3'd0, 8'h00};
    vecs[9]  = '{H, H, L, H, 8'hB3, 2'd0, 4'hD, H, 2'd3, L, 4'h6, 3'd0, 8'h00};
    vecs[10] = '{H, H, L, H, 8'hB4, 2'd0, 4'hD, H, 2'd0, L, 4'hA, 3'd0, 8'h00};
    vecs[11] = '{H, H, L, H, 8'hA0, 2'd0, 4'hD, H, 2'd2, L, 4'h3, 3'd0, 8'h00};
    vecs[12] = '{H, H, L, H, 8'hA1, 2'd0, 4'hD, H, 2'd3, L, 4'h6, 3'd0, 8'h00};
    vecs[13] = '{H, H, L, H, 8'hA2, 2'd0, 4'hD, H, 2'd0, L, 4'hA, 3'd5, 8'hB1};
    vecs[14] = '{H, H, L, L, 8'h00, 2'd0, 4'hD, H, 2'd2, L, 4'h3, 3'd0, 8'h00};
    // fill all four slots, then free only ch3
    vecs[15] = '{H, H, L, H, 8'hC0, 2'd0, 4'h0, H, 2'd2, L, 4'h2, 3'd0, 8'h00};
    vecs[16] = '{H, H, L, H, 8'hC1, 2'd0, 4'h0, H, 2'd3, L, 4'h6, 3'd0, 8'h00};
    vecs[17] = '{H, H, L, H, 8'hC2, 2'd0, 4'h0, H, 2'd0, L, 4'hE, 3'd0, 8'h00};
    vecs[18] = '{H, H, L, H, 8'hC3, 2'd0, 4'h0, L, 2'd0, L, 4'hF, 3'd4, 8'hC2};
    vecs[19] = '{H, H, L, H, 8'hC3, 2'd0, 4'h0, L, 2'd0, L, 4'hF, 3'd6, 8'hC0};
    vecs[20] = '{H, H, L, H, 8'hC3, 2'd0, 4'h8, H, 2'd3, L, 4'hF, 3'd0, 8'h00};
    vecs[21] = '{H, H, L, L, 8'h00, 2'd0, 4'h0, L, 2'd0, L, 4'hF, 3'd7, 8'hC3};
    // disable with two slots held, drain, then re-enable in directed mode
    vecs[22] = '{H, H, L, L, 8'h00, 2'd0, 4'h3, H, 2'd0, L, 4'hF, 3'd0, 8'h00};
    vecs[23] = '{H, L, L, L, 8'h00, 2'd0, 4'h0, H, 2'd0, L, 4'hC, 3'd0, 8'h00};
    vecs[24] = '{H, L, L, L, 8'h00, 2'd0, 4'h0, L, 2'd0, L, 4'hC, 3'd0, 8'h00};
    vecs[25] = '{H, L, L, L, 8'h00, 2'd0, 4'h4, L, 2'd0, L, 4'hC, 3'd0, 8'h00};
    vecs[26] = '{H, H, H, L, 8'h00, 2'd0, 4'h8, L, 2'd0, L, 4'h8, 3'd0, 8'h00};
    vecs[27] = '{H, H, H, L, 8'h00, 2'd0, 4'h0, L, 2'd0, L, 4'h0, 3'd0, 8'h00};
    vecs[28] = '{H, H, H, L, 8'h00, 2'd0, 4'h0, L, 2'd0, H, 4'h0, 3'd0, 8'h00};
    vecs[29] = '{H, H, L, H, 8'h77, 2'd2, 4'h0, H, 2'd2, L, 4'h0, 3'd0, 8'h00};
    vecs[30] = '{H, H, L, H, 8'h5A, 2'd2, 4'h0, L, 2'd0, L, 4'h4, 3'd0, 8'h00};
    vecs[31] = '{H, H, L, H, 8'h5A, 2'd2, 4'h0, L, 2'd0, L, 4'h4, 3'd6, 8'h77};
    vecs[32] = '{H, H, L, H, 8'h5A, 2'd2, 4'h4, H, 2'd2, L, 4'h4, 3'd0, 8'h00};
    vecs[33] = '{H, H, L, L, 8'h00, 2'd2, 4'h0, L, 2'd0, L, 4'h4, 3'd6, 8'h5A};
    vecs[34] = '{H, H, L, H, 8'h66, 2'd0, 4'h0, H, 2'd0, L, 4'h4, 3'd0, 8'h00};
    vecs[35] = '{H, H, L, H, 8'h67, 2'd1, 4'h0, H, 2'd1, L, 4'h5, 3'd0, 8'h00};
    // reset with words held, then round-robin restarts at ch0
    vecs[36] = '{L, H, L, L, 8'h00, 2'd0, 4'h0, L, 2'd0, L, 4'h7, 3'd0, 8'h00};
    vecs[37] = '{H, L, L, L, 8'h00, 2'd0, 4'h0, L, 2'd0, H, 4'h0, 3'd6, 8'h00};
    vecs[38] = '{H, H, L, L, 8'h00, 2'd0, 4'h0, L, 2'd0, H, 4'h0, 3'd0, 8'h00};
    vecs[39] = '{H, H, L, H, 8'hE0, 2'd0, 4'hF, H, 2'd0, L, 4'h0, 3'd0, 8'h00};
    vecs[40] = '{H, H, L, H, 8'hE1, 2'd0, 4'hF, H, 2'd1, L, 4'h1, 3'd0, 8'h00};
    vecs[41] = '{H, H, L, L, 8'h00, 2'd0, 4'hF, H, 2'd2, L, 4'h2, 3'd0, 8'h00};
    vecs[42] = '{H, H, L, L, 8'h00, 2'd0, 4'hF, H, 2'd2, L, 4'h0, 3'd0, 8'h00};

    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_dest   = 2'd0;
    bus.out_ready = 4'h0;
    rst_n = 1'b0;
    en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset idle", 32'(idle), 32'd1);
    chk("reset in_ready", 32'(bus.in_ready), 32'd0);
    chk("reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset out_data", bus.out_data, 32'd0);
    chk("reset sel", 32'(bus.sel), 32'd0);

    for (int n = 0; n < NV; n++) apply(n, vecs[n]);

    for (int i = 0; i < 4; i++) begin
      chk($sformatf("sb leftover ch%0d", i), 32'(sbq[i].size()), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
